// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the core and muldiv_seq (start/op/a/b in; busy/done/result/div_by_zero out)
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            div_by_zero;
  modport master (output start, op, a, b, input busy, done, result, div_by_zero);
  modport slave (input start, op, a, b, output busy, done, result, div_by_zero);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32-bit mul-low/divu/remu using the shared ALU for one add/sub per cycle (clk, reset, bus: request/response, alu_*: ALU borrow port)
module muldiv_seq #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] ALU_ADD = 4'd2,
  parameter logic [3:0] ALU_SUB = 4'd6
) (
  input  logic            clk,
  input  logic            reset,
  muldiv_seq_if.slave     bus,
  output logic            alu_grant,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  // acc: product accumulator / partial remainder; x: multiplicand / divisor;
  // y: multiplier / dividend, which fills with quotient bits as it shifts left
  logic [XLEN-1:0] acc, x, y, rs, acc_n, y_n, result;
  logic [4:0] count;
  logic [1:0] op_r;
  logic dbz, ge, last, accept, zero, busy;
  always_comb begin
    // msb (acc[XLEN-1]) set means the 33-bit shifted remainder already exceeds any divisor
    rs = {acc[XLEN-2:0], y[XLEN-1]};
    ge = acc[XLEN-1] | (rs >= x);
    acc_n = state == MUL ? (y[0] ? alu_out : acc) : (ge ? alu_out : rs);
    y_n = state == MUL ? y >> 1 : {y[XLEN-2:0], ge};
    last = count == 5'd31;
    busy = state == MUL || state == DIV;
    zero = bus.b == '0;
    accept = state == IDLE && bus.start && bus.op != 2'd3;
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = bus.op == 2'd0 ? MUL : zero ? DONE : DIV;
      MUL, DIV: if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
    alu_ctl = state == DIV ? ALU_SUB : ALU_ADD;
    alu_a = state == MUL ? acc : state == DIV ? rs : '0;
    alu_b = busy ? x : '0;
  end
  assign alu_grant = busy;
  assign bus.busy = busy;
  assign bus.done = state == DONE;
  assign bus.result = result;
  assign bus.div_by_zero = dbz;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      x <= '0;
      y <= '0;
      count <= '0;
      op_r <= '0;
      dbz <= 1'b0;
      result <= '0;
    end else if (accept) begin
      acc <= '0;
      x <= bus.b;
      y <= bus.a;
      count <= '0;
      op_r <= bus.op;
      dbz <= bus.op != 2'd0 && zero;
      if (bus.op != 2'd0 && zero) result <= bus.op == 2'd1 ? '1 : bus.a;
    end else if (busy) begin
      acc <= acc_n;
      y <= y_n;
      x <= state == MUL ? x << 1 : x;
      count <= count + 5'd1;
      if (last) result <= op_r == 2'd1 ? y_n : acc_n;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq with a behavioural ALU
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic alu_grant;
  logic [3:0] alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;
  int compared = 0;
  int mismatched = 0;
  muldiv_seq_if bus ();
  muldiv_seq dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .alu_grant(alu_grant),
    .alu_ctl(alu_ctl),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_out(alu_out)
  );
  always #5 clk = ~clk;
  assign alu_out = alu_ctl == 4'd6 ? alu_a - alu_b : alu_a + alu_b;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat,
                     input logic [3:0] exp_ctl, input bit hold);
    int lat = 1;
    int bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    bus.a = 32'hdead_beef;
    bus.b = 32'h0bad_f00d;
    while (!bus.done && lat < 100) begin
      if (bus.busy !== 1'b1 || alu_grant !== 1'b1 || alu_ctl !== exp_ctl) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy/ctl"}, 32'(bad), 32'd0);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " dbz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_dbz});
    @(posedge clk);
    #1;
    check({tag, " done fell"}, {30'd0, bus.done, bus.busy}, 32'd0);
    check({tag, " result held"}, bus.result, exp_res);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset flags", {28'd0, bus.busy, bus.done, bus.div_by_zero, alu_grant}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset alu_ctl", {28'd0, alu_ctl}, 32'd2);
    check("reset alu_ab", alu_a | alu_b, 32'd0);
    run("mul 7*6", 2'd0, 32'd7, 32'd6, 32'd42, 1'b0, 33, 4'd2, 1'b0);
    run("mul ffffffff*2", 2'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 33, 4'd2, 1'b0);
    run("mul wrap", 2'd0, 32'h10000, 32'h10000, 32'd0, 1'b0, 33, 4'd2, 1'b0);
    run("divu 100/7", 2'd1, 32'd100, 32'd7, 32'd14, 1'b0, 33, 4'd6, 1'b0);
    run("remu 100%7", 2'd2, 32'd100, 32'd7, 32'd2, 1'b0, 33, 4'd6, 1'b0);
    run("divu big", 2'd1, 32'hFFFFFFFF, 32'h80000001, 32'd1, 1'b0, 33, 4'd6, 1'b0);
    run("remu big", 2'd2, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 33, 4'd6, 1'b0);
    run("divu by 1", 2'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 33, 4'd6, 1'b0);
    run("divu by 0", 2'd1, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1, 4'd2, 1'b0);
    run("remu by 0", 2'd2, 32'd5, 32'd0, 32'd5, 1'b1, 1, 4'd2, 1'b0);
    run("mul clears dbz", 2'd0, 32'd3, 32'd5, 32'd15, 1'b0, 33, 4'd2, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("op3 ignored busy", {30'd0, bus.busy, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    check("op3 ignored later", {30'd0, bus.busy, bus.done}, 32'd0);
    check("op3 result kept", bus.result, 32'd15);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 32'd9;
    bus.b = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid reset flags", {28'd0, bus.busy, bus.done, bus.div_by_zero, alu_grant}, 32'd0);
    check("mid reset result", bus.result, 32'd0);
    check("mid reset alu_ctl", {28'd0, alu_ctl}, 32'd2);
    check("mid reset alu_ab", alu_a | alu_b, 32'd0);
    run("mul start held", 2'd0, 32'd12, 32'd12, 32'd144, 1'b0, 33, 4'd2, 1'b1);
    run("divu after hold", 2'd1, 32'd144, 32'd12, 32'd12, 1'b0, 33, 4'd6, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer that performs 32-bit unsigned multiply (low word), divide and remainder by issuing one add/sub per cycle to the shared ALU.
- Sits beside the ALU in the execute stage. It owns the ALU ctl/a/b inputs while busy; the core muxes them in when alu_grant is high.
- Shifts, counting and unsigned compare are done locally. The ALU supplies only the sums and differences.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- ALU_ADD, 4'd2, ALU ctl code for add.
- ALU_SUB, 4'd6, ALU ctl code for sub.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  2  0=MUL (low 32 bits), 1=DIVU (quotient), 2=REMU (remainder), 3=reserved
- a  in  32  multiplicand / dividend; captured on accept
- b  in  32  multiplier / divisor; captured on accept
- busy  out  1  high in MUL and DIV states
- done  out  1  one-cycle pulse in DONE state
- result  out  32  valid from DONE; held until the next accepted start
- div_by_zero  out  1  set with done when op 1/2 and b==0; held with result
- alu_grant  out  1  equals busy
- alu_ctl  out  4  ALU control code
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_out  in  32  ALU result, combinational, same cycle

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it forces IDLE from any state, including mid-operation.
- Reset values:
  - busy=0, done=0, result=0, div_by_zero=0.
  - Iteration count=0; all operand registers=0.
  - alu_ctl=ALU_ADD, alu_a=0, alu_b=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 with op 0 -> capture operands, go to MUL.
  - start=1 with op 1 or 2 and b!=0 -> capture operands, go to DIV.
  - start=1 with op 1 or 2 and b==0 -> go to DONE with no iterations. result = 32'hFFFFFFFF for DIVU, a for REMU; div_by_zero=1.
  - start=1 with op 3 -> ignored, stays IDLE.
  - Outside MUL/DIV, alu_ctl=ALU_ADD and alu_a=alu_b=0.
- MUL (32 cycles, count 0..31), shift-add:
  - Drive alu_ctl=ALU_ADD, alu_a=acc, alu_b=mcand.
  - If mplier[0]=1, acc<=alu_out.
  - Then mcand<<=1 and mplier>>=1; carry beyond bit 31 is discarded.
  - After count 31 -> DONE with result=acc (mod 2^32).
- DIV (32 cycles), restoring:
  - Form the 33-bit shifted remainder {rem, dvd[31]}; call its high bit msb and its low 32 bits rs.
  - Drive alu_ctl=ALU_SUB, alu_a=rs, alu_b=divisor.
  - If msb=1 or rs>=divisor (unsigned, local compare): rem<=alu_out, quotient bit=1.
  - Otherwise rem<=rs, quotient bit=0.
  - dvd<<=1 and the quotient bit shifts into the quotient LSB.
  - After count 31 -> DONE with result = quotient for op 1, rem for op 2.
- DONE: done=1 for exactly one cycle, then IDLE. result and div_by_zero hold until the next accepted start, which clears div_by_zero.
- Latency:
  - Start accepted at edge N -> done high during cycle N+33.
  - Divide-by-zero: done high during cycle N+1.
- Back-to-back: start is not sampled in DONE. The earliest next accept is the edge after done falls.
- start asserted while busy or in DONE is ignored and not queued. Operand inputs are don't-care after accept.

Test Plan:
- MUL a=7, b=6 -> busy for 32 cycles; done pulse at cycle 33; result=42; ALU sees ctl=2 every busy cycle.
- MUL a=32'hFFFFFFFF, b=2 -> result=32'hFFFFFFFE. MUL a=32'h10000, b=32'h10000 -> result=0 (wrap).
- DIVU a=100, b=7 -> result=14. REMU same operands -> result=2; div_by_zero=0; ALU ctl=6 while busy.
- DIVU a=32'hFFFFFFFF, b=32'h80000001 -> result=1. REMU -> result=32'h7FFFFFFE (exercises msb/unsigned-compare path). DIVU a=32'hFFFFFFFF, b=1 -> result=32'hFFFFFFFF.
- DIVU a=5, b=0 -> done the cycle after accept, result=32'hFFFFFFFF, div_by_zero=1. REMU a=5, b=0 -> result=5. Next valid start clears div_by_zero.
- Start MUL, pulse reset at count 10 -> next cycle busy=0, done=0, result=0, alu outputs at reset values. start held high during busy of a following op -> no restart, single done pulse.
